// File: rtl/fifo_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader_pkg
// Shared constants and helpers for the FIFO read-side stream adapter.
//   OCC_W / SKID_DEPTH : occupancy counter width and skid buffer depth
//   OCC_EMPTY/ONE/FULL : encoded occupancy values
//   credit_ok()        : read-issue credit test used by the top level
// -----------------------------------------------------------------------------
package fifo_stream_reader_pkg;

   localparam int OCC_W      = 2;
   localparam int SKID_DEPTH = 2;

   typedef logic [OCC_W-1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

   localparam logic [OCC_W:0] DEPTH_LIM = SKID_DEPTH[OCC_W:0];

   // Words already committed to the buffer after this cycle's pop: buffered
   // plus the one still in flight from the FIFO. A new read may only be
   // issued while that total leaves a free slot for its data.
   function automatic logic credit_ok(input occ_t occ, input logic inflight,
                                      input logic pop);
      logic [OCC_W:0] committed;
      committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight}
                - {{OCC_W{1'b0}}, pop};
      return committed < DEPTH_LIM;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader_skid_buf2
// Two-entry register buffer absorbing the FIFO's 1-cycle read latency.
// slot0 is the head; a pop while full shifts slot1 into slot0, and a push in
// the same cycle lands in the first slot left free after the pop.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clr            synchronous flush (occupancy and slots to zero)
//   push/push_data word returning from the FIFO
//   pop            head word consumed this cycle
//   occ            current occupancy (0..2)
//   head_data      slot0 contents
// -----------------------------------------------------------------------------
module fifo_stream_reader_skid_buf2
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output occ_t             occ,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   logic             pop_eff;
   occ_t             occ_after_pop;
   occ_t             occ_next;

   assign pop_eff       = pop & (occ != OCC_EMPTY);
   assign occ_after_pop = occ - occ_t'(pop_eff);
   assign occ_next      = occ_after_pop + occ_t'(push);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ   <= OCC_EMPTY;
         slot0 <= '0;
         slot1 <= '0;
      end else if (clr) begin
         occ   <= OCC_EMPTY;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         // The credit check upstream must never let a third word arrive.
         assert (!(push && (occ_after_pop == OCC_FULL)));
         if (pop_eff && (occ == OCC_FULL)) begin
            slot0 <= slot1;
         end
         if (push) begin
            if (occ_after_pop == OCC_EMPTY) begin
               slot0 <= push_data;
            end else begin
               slot1 <= push_data;
            end
         end
         occ <= occ_next;
      end
   end

   assign head_data = slot0;

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Read-side consumer for an async FIFO read port. Turns the FIFO's
// enable / 1-cycle-latency data / empty interface into a valid/ready stream,
// sustaining one word per cycle through a 2-entry skid buffer with credit
// accounting, without over-reading the FIFO or dropping words.
//
// Optional build macro: FIFO_STREAM_READER_LAST_EN
//   defined   : packet counter drives m_last every PKT_LEN words
//   undefined : m_last tied low, port list unchanged
//
// Ports:
//   clk, rst            read clock, asynchronous active-low reset
//   clr                 synchronous flush of buffer, in-flight read, counters
//   fifo_en             FIFO read enable (combinational, gated by rst/clr)
//   fifo_dout           FIFO read data, valid the cycle after fifo_en
//   fifo_empty          FIFO empty flag
//   fifo_almost_empty   FIFO almost-empty flag, registered to low_water
//   m_valid/m_ready     stream handshake
//   m_data              stream data (buffer head)
//   m_last              last word of packet
//   rd_count            words accepted on the stream, wrapping
//   low_water           registered fifo_almost_empty
// -----------------------------------------------------------------------------
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 16,
   parameter int PKT_LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic             fifo_en,
   input  logic [WIDTH-1:0] fifo_dout,
   input  logic             fifo_empty,
   input  logic             fifo_almost_empty,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [CNT_W-1:0] rd_count,
   output logic             low_water
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   if ((PKT_LEN < 1) || (PKT_LEN > (2**CNT_W) - 1)) begin : g_bad_pkt_len
      $error("fifo_stream_reader: PKT_LEN out of range for CNT_W");
   end

   occ_t             occ;
   logic             inflight;
   logic             pop;
   logic             push;
   logic [WIDTH-1:0] head_data;

   assign pop = m_valid & m_ready;

   // Reset gates the strobe directly so the FIFO is never read while the
   // buffer state is being held in reset.
   assign fifo_en = rst & ~fifo_empty & ~clr & credit_ok(occ, inflight, pop);

   // A word returning during clr belongs to a read issued before the flush
   // and is dropped.
   assign push = inflight & ~clr;

   fifo_stream_reader_skid_buf2 #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (push),
      .push_data (fifo_dout),
      .pop       (pop),
      .occ       (occ),
      .head_data (head_data)
   );

   assign m_valid = (occ != OCC_EMPTY);
   assign m_data  = head_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight  <= 1'b0;
         rd_count  <= '0;
         low_water <= 1'b0;
      end else begin
         low_water <= fifo_almost_empty;
         if (clr) begin
            inflight <= 1'b0;
            rd_count <= '0;
         end else begin
            inflight <= fifo_en;
            if (pop) begin
               rd_count <= rd_count + CNT_ONE;
            end
         end
      end
   end

`ifdef FIFO_STREAM_READER_LAST_EN
   localparam logic [CNT_W-1:0] PKT_END = CNT_W'(PKT_LEN - 1);

   logic [CNT_W-1:0] pkt_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_cnt <= '0;
      end else if (clr) begin
         pkt_cnt <= '0;
      end else if (pop) begin
         pkt_cnt <= m_last ? '0 : pkt_cnt + CNT_ONE;
      end
   end

   assign m_last = m_valid & (pkt_cnt == PKT_END);
`else
   assign m_last = 1'b0;
`endif

endmodule
